l1_meta_array_ctrl: RTL and testbench

- Owns the L1 data-cache metadata storage: N_SETS x N_WAYS entries, each entry a {tag, coh} pair in L1Metadata layout.
- Shares one single-ported array between one writer and N_RD readers:
  - the writer is the miss/refill path, sending L1MetaWriteReq fields;
  - the readers are the pipeline and the prober, sending L1MetaReadReq fields.
- After reset, and on a flush request, sweeps every set to invalid before accepting traffic.
- Returns per-way metadata and a tag-match hit vector one cycle after a read is accepted.

---
 rtl/l1_meta_array_ctrl.sv | 169 ++++++++++++++++
 tb/tb_l1_meta_array_ctrl.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_meta_array_ctrl.sv
// L1 data-cache metadata array controller.
// One refill writer, N_RD prioritised readers, sweep-to-invalid on init/flush.
module l1_meta_array_ctrl #(
  parameter int N_SETS   = 64,
  parameter int N_WAYS   = 4,
  parameter int TAG_BITS = 20,
  parameter int COH_BITS = 2,
  parameter int N_RD     = 2,
  parameter int IDX      = $clog2(N_SETS),
  parameter int ID       = (N_RD > 1) ? $clog2(N_RD) : 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                flush_req,
  output logic                                init_done,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [IDX-1:0]                      wr_idx,
  input  logic [N_WAYS-1:0]                   wr_way_en,
  input  logic [TAG_BITS-1:0]                 wr_tag,
  input  logic [COH_BITS-1:0]                 wr_coh,
  input  logic [N_RD-1:0]                     rd_valid,
  output logic [N_RD-1:0]                     rd_ready,
  input  logic [N_RD*IDX-1:0]                 rd_idx,
  input  logic [N_RD*TAG_BITS-1:0]            rd_tag,
  output logic                                resp_valid,
  output logic [ID-1:0]                       resp_id,
  output logic [N_WAYS*(TAG_BITS+COH_BITS)-1:0] resp_meta,
  output logic [N_WAYS-1:0]                   resp_hit
);

  localparam int E = TAG_BITS + COH_BITS;

  typedef enum logic {INIT, RUN} state_e;

  state_e state_q, state_d;
  logic [IDX-1:0] cnt_q, cnt_d;
  logic init_done_q, init_done_d;
  logic resp_valid_q, resp_valid_d;
  logic [ID-1:0] resp_id_q, resp_id_d;
  logic [N_WAYS*E-1:0] resp_meta_q, resp_meta_d;
  logic [N_WAYS-1:0] resp_hit_q, resp_hit_d;

  logic [E-1:0] mem_q [N_SETS][N_WAYS];
  logic [N_WAYS-1:0] mem_we;
  logic [IDX-1:0] mem_widx;
  logic [E-1:0] mem_wdata;

  logic run;
  logic wr_go;
  logic rd_go;
  logic [ID-1:0] gnt_id;
  logic [IDX-1:0] sel_idx;
  logic [TAG_BITS-1:0] sel_tag;

  assign run = (state_q == RUN);
  assign wr_go = run && !flush_req && wr_valid;
  assign wr_ready = wr_go;
  assign rd_go = |rd_ready;

  // Fixed-priority read grant; lowest index wins, writer and flush block all reads
  always_comb begin
    rd_ready = '0;
    gnt_id = '0;
    sel_idx = '0;
    sel_tag = '0;
    if (run && !flush_req && !wr_valid) begin
      for (int i = N_RD - 1; i >= 0; i--) begin
        if (rd_valid[i]) begin
          rd_ready = '0;
          rd_ready[i] = 1'b1;
          gnt_id = ID'(i);
          sel_idx = rd_idx[i*IDX +: IDX];
          sel_tag = rd_tag[i*TAG_BITS +: TAG_BITS];
        end
      end
    end
  end

  // Single array write port: sweep clears a whole set, refill writes masked ways
  always_comb begin
    mem_we = '0;
    mem_widx = wr_idx;
    mem_wdata = {wr_tag, wr_coh};
    if (!run) begin
      mem_we = '1;
      mem_widx = cnt_q;
      mem_wdata = '0;
    end else if (wr_go) begin
      mem_we = wr_way_en;
    end
  end

  // Metadata storage, no reset: contents are rebuilt by the sweep
  always_ff @(posedge clock) begin
    for (int w = 0; w < N_WAYS; w++) begin
      if (mem_we[w]) mem_q[mem_widx][w] <= mem_wdata;
    end
  end

  // INIT sweeps one set per cycle, RUN serves traffic until a flush
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + IDX'(1);
        if (cnt_q == IDX'(N_SETS - 1)) begin
          state_d = RUN;
          cnt_d = '0;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (flush_req) begin
          state_d = INIT;
          cnt_d = '0;
          init_done_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Capture granted set and tag compare; outputs hold between responses
  always_comb begin
    resp_valid_d = rd_go;
    resp_id_d = resp_id_q;
    resp_meta_d = resp_meta_q;
    resp_hit_d = resp_hit_q;
    if (rd_go) begin
      resp_id_d = gnt_id;
      for (int w = 0; w < N_WAYS; w++) begin
        resp_meta_d[w*E +: E] = mem_q[sel_idx][w];
        resp_hit_d[w] = (mem_q[sel_idx][w][E-1:COH_BITS] == sel_tag) &&
                        (mem_q[sel_idx][w][COH_BITS-1:0] != '0);
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      init_done_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q <= '0;
      resp_meta_q <= '0;
      resp_hit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_done_q <= init_done_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q <= resp_id_d;
      resp_meta_q <= resp_meta_d;
      resp_hit_q <= resp_hit_d;
    end
  end

  assign init_done = init_done_q;
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_meta = resp_meta_q;
  assign resp_hit = resp_hit_q;

endmodule

// File: tb/tb_l1_meta_array_ctrl.sv
// Bench for l1_meta_array_ctrl.
// Directed scenarios plus randomized traffic against an array model.
module tb_l1_meta_array_ctrl;

  localparam int NS = 64;
  localparam int NW = 4;
  localparam int TB = 20;
  localparam int CB = 2;
  localparam int NR = 2;
  localparam int IDX = 6;
  localparam int ID = 1;
  localparam int E = TB + CB;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush_req = 1'b0;
  logic init_done;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [IDX-1:0] wr_idx = '0;
  logic [NW-1:0] wr_way_en = '0;
  logic [TB-1:0] wr_tag = '0;
  logic [CB-1:0] wr_coh = '0;
  logic [NR-1:0] rd_valid = '0;
  logic [NR-1:0] rd_ready;
  logic [NR*IDX-1:0] rd_idx = '0;
  logic [NR*TB-1:0] rd_tag = '0;
  logic resp_valid;
  logic [ID-1:0] resp_id;
  logic [NW*E-1:0] resp_meta;
  logic [NW-1:0] resp_hit;

  int n_tests = 0;
  int n_fail = 0;

  logic [E-1:0] model [NS][NW];

  l1_meta_array_ctrl dut (
    .clock(clock),
    .reset_n(reset_n),
    .flush_req(flush_req),
    .init_done(init_done),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_idx(wr_idx),
    .wr_way_en(wr_way_en),
    .wr_tag(wr_tag),
    .wr_coh(wr_coh),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_idx(rd_idx),
    .rd_tag(rd_tag),
    .resp_valid(resp_valid),
    .resp_id(resp_id),
    .resp_meta(resp_meta),
    .resp_hit(resp_hit)
  );

  always #5 clock = ~clock;

  function automatic void model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        model[s][w] = '0;
  endfunction

  function automatic void model_write(input int s, input logic [NW-1:0] en,
                                      input logic [TB-1:0] t, input logic [CB-1:0] c);
    for (int w = 0; w < NW; w++)
      if (en[w]) model[s][w] = {t, c};
  endfunction

  function automatic logic [NW*E-1:0] exp_meta(input int s);
    logic [NW*E-1:0] m;
    for (int w = 0; w < NW; w++) m[w*E +: E] = model[s][w];
    return m;
  endfunction

  function automatic logic [NW-1:0] exp_hit(input int s, input logic [TB-1:0] t);
    logic [NW-1:0] h;
    for (int w = 0; w < NW; w++)
      h[w] = (model[s][w][E-1:CB] == t) && (model[s][w][CB-1:0] != 0);
    return h;
  endfunction

  task automatic nx();
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) nx();
    n_tests++;
    if ({init_done, resp_valid, resp_id, resp_hit} !== '0 || resp_meta !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got done=%b v=%b id=%b hit=%b meta=%h want all 0",
               init_done, resp_valid, resp_id, resp_hit, resp_meta);
    end
    rd_valid = 2'b01;
    rd_idx[0 +: IDX] = IDX'(5);
    rd_tag[0 +: TB] = '0;
    reset_n = 1'b1;
    model_clear();
    for (int k = 0; k < NS; k++) begin
      #1;
      n_tests++;
      if (init_done !== 1'b0 || rd_ready !== 2'b00 || wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sweep cyc %0d: got done=%b rdy=%b wrdy=%b want 0 00 0",
                 k, init_done, rd_ready, wr_ready);
      end
      nx();
    end
    #1;
    n_tests++;
    if (init_done !== 1'b1 || rd_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_done: got done=%b rdy=%b want 1 01", init_done, rd_ready);
    end
    nx();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_hit !== 4'b0000 ||
        resp_meta !== exp_meta(5)) begin
      n_fail++;
      $display("FAIL first_read: got v=%b id=%b hit=%b meta=%h want 1 0 0000 %h",
               resp_valid, resp_id, resp_hit, resp_meta, exp_meta(5));
    end
    rd_valid = 2'b00;
    nx();
  endtask

  task automatic test_write_read();
    logic [E-1:0] m2;
    wr_valid = 1'b1;
    wr_idx = IDX'(3);
    wr_way_en = 4'b0100;
    wr_tag = 20'h12345;
    wr_coh = 2'd2;
    #1;
    n_tests++;
    if (wr_ready !== 1'b1 || rd_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_grant: got wrdy=%b rdy=%b want 1 00", wr_ready, rd_ready);
    end
    model_write(3, 4'b0100, 20'h12345, 2'd2);
    nx();
    wr_valid = 1'b0;
    rd_valid = 2'b01;
    rd_idx[0 +: IDX] = IDX'(3);
    rd_tag[0 +: TB] = 20'h12345;
    nx();
    rd_valid = 2'b00;
    m2 = resp_meta[2*E +: E];
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_hit !== 4'b0100 ||
        m2 !== {20'h12345, 2'd2}) begin
      n_fail++;
      $display("FAIL write_read: got v=%b id=%b hit=%b way2=%h want 1 0 0100 %h",
               resp_valid, resp_id, resp_hit, m2, {20'h12345, 2'd2});
    end
    n_tests++;
    if (resp_meta !== exp_meta(3)) begin
      n_fail++;
      $display("FAIL write_read_meta: got %h want %h", resp_meta, exp_meta(3));
    end
    nx();
    n_tests++;
    if (resp_valid !== 1'b0 || resp_hit !== 4'b0100 || resp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_hold: got v=%b hit=%b id=%b want 0 0100 0",
               resp_valid, resp_hit, resp_id);
    end
  endtask

  task automatic test_back_to_back();
    logic [TB-1:0] ta;
    ta = TB'($urandom);
    wr_valid = 1'b1;
    wr_idx = IDX'(10);
    wr_way_en = 4'b0001;
    wr_tag = ta;
    wr_coh = 2'd1;
    rd_valid = 2'b11;
    rd_idx = {IDX'(3), IDX'(10)};
    rd_tag = {TB'(20'h12345), ta};
    #1;
    n_tests++;
    if (wr_ready !== 1'b1 || rd_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_write: got wrdy=%b rdy=%b want 1 00", wr_ready, rd_ready);
    end
    model_write(10, 4'b0001, ta, 2'd1);
    nx();
    wr_valid = 1'b0;
    #1;
    n_tests++;
    if (rd_ready !== 2'b01 || wr_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_rd0a: got rdy=%b wrdy=%b v=%b want 01 0 0",
               rd_ready, wr_ready, resp_valid);
    end
    nx();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_hit !== 4'b0001 ||
        resp_meta !== exp_meta(10) || rd_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL prio_rd0b: got v=%b id=%b hit=%b rdy=%b want 1 0 0001 01",
               resp_valid, resp_id, resp_hit, rd_ready);
    end
    nx();
    rd_valid = 2'b10;
    #1;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || rd_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_rd1_grant: got v=%b id=%b rdy=%b want 1 0 10",
               resp_valid, resp_id, rd_ready);
    end
    nx();
    rd_valid = 2'b00;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_meta !== exp_meta(3) ||
        resp_hit !== exp_hit(3, 20'h12345)) begin
      n_fail++;
      $display("FAIL prio_rd1_resp: got v=%b id=%b hit=%b want 1 1 %b",
               resp_valid, resp_id, resp_hit, exp_hit(3, 20'h12345));
    end
    nx();
  endtask

  task automatic test_coh_zero();
    wr_valid = 1'b1;
    wr_idx = IDX'(7);
    wr_way_en = 4'b0001;
    wr_tag = 20'hABCDE;
    wr_coh = 2'd3;
    model_write(7, 4'b0001, 20'hABCDE, 2'd3);
    nx();
    wr_way_en = 4'b0010;
    wr_coh = 2'd0;
    model_write(7, 4'b0010, 20'hABCDE, 2'd0);
    nx();
    wr_valid = 1'b0;
    rd_valid = 2'b10;
    rd_idx[IDX +: IDX] = IDX'(7);
    rd_tag[TB +: TB] = 20'hABCDE;
    #1;
    n_tests++;
    if (rd_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL coh0_grant: got rdy=%b want 10", rd_ready);
    end
    nx();
    rd_valid = 2'b00;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_hit !== 4'b0001 ||
        resp_meta !== exp_meta(7)) begin
      n_fail++;
      $display("FAIL coh0_hit: got v=%b id=%b hit=%b meta=%h want 1 1 0001 %h",
               resp_valid, resp_id, resp_hit, resp_meta, exp_meta(7));
    end
    nx();
  endtask

  task automatic test_random();
    logic [TB-1:0] pool [4];
    logic [NR-1:0] er;
    logic ew;
    logic pend;
    logic [ID-1:0] pid;
    logic [NW*E-1:0] pmeta;
    logic [NW-1:0] phit;
    int ps;
    pool[0] = 20'h00000;
    pool[1] = 20'h12345;
    pool[2] = 20'hABCDE;
    pool[3] = 20'hFFFFF;
    for (int n = 0; n < 400; n++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_idx = IDX'($urandom_range(0, 7));
      wr_way_en = NW'($urandom);
      wr_tag = pool[$urandom_range(0, 3)];
      wr_coh = CB'($urandom);
      rd_valid = NR'($urandom);
      rd_idx = {IDX'($urandom_range(0, 7)), IDX'($urandom_range(0, 7))};
      rd_tag = {pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]};
      ew = wr_valid;
      er = 2'b00;
      if (!ew && rd_valid[0]) er = 2'b01;
      else if (!ew && rd_valid[1]) er = 2'b10;
      #1;
      n_tests++;
      if (wr_ready !== ew || rd_ready !== er) begin
        n_fail++;
        $display("FAIL rand_grant %0d: got wrdy=%b rdy=%b want %b %b",
                 n, wr_ready, rd_ready, ew, er);
      end
      pend = (er != 2'b00);
      pid = er[1];
      ps = int'(rd_idx[pid*IDX +: IDX]);
      pmeta = exp_meta(ps);
      phit = exp_hit(ps, rd_tag[pid*TB +: TB]);
      if (ew) model_write(int'(wr_idx), wr_way_en, wr_tag, wr_coh);
      nx();
      n_tests++;
      if (resp_valid !== pend ||
          (pend && (resp_id !== pid || resp_meta !== pmeta || resp_hit !== phit))) begin
        n_fail++;
        $display("FAIL rand_resp %0d: got v=%b id=%b hit=%b meta=%h want %b %b %b %h",
                 n, resp_valid, resp_id, resp_hit, resp_meta, pend, pid, phit, pmeta);
      end
    end
    wr_valid = 1'b0;
    rd_valid = 2'b00;
    nx();
  endtask

  task automatic test_flush();
    wr_valid = 1'b1;
    wr_idx = IDX'(20);
    wr_way_en = 4'b1111;
    wr_tag = 20'h55555;
    wr_coh = 2'd3;
    model_write(20, 4'b1111, 20'h55555, 2'd3);
    nx();
    wr_valid = 1'b0;
    rd_valid = 2'b01;
    rd_idx[0 +: IDX] = IDX'(20);
    rd_tag[0 +: TB] = 20'h55555;
    nx();
    flush_req = 1'b1;
    wr_valid = 1'b1;
    #1;
    n_tests++;
    if (wr_ready !== 1'b0 || rd_ready !== 2'b00 || init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_nogrant: got wrdy=%b rdy=%b done=%b want 0 00 1",
               wr_ready, rd_ready, init_done);
    end
    n_tests++;
    if (resp_valid !== 1'b1 || resp_hit !== 4'b1111 || resp_meta !== exp_meta(20)) begin
      n_fail++;
      $display("FAIL flush_pending_resp: got v=%b hit=%b want 1 1111", resp_valid, resp_hit);
    end
    nx();
    model_clear();
    for (int k = 0; k < NS; k++) begin
      flush_req = (k == 10);
      wr_valid = (k < 32);
      #1;
      n_tests++;
      if (init_done !== 1'b0 || rd_ready !== 2'b00 || wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_sweep cyc %0d: got done=%b rdy=%b wrdy=%b want 0 00 0",
                 k, init_done, rd_ready, wr_ready);
      end
      nx();
    end
    flush_req = 1'b0;
    rd_tag[0 +: TB] = '0;
    #1;
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: got done=%b want 1", init_done);
    end
    for (int s = 0; s < NS; s++) begin
      rd_idx[0 +: IDX] = IDX'(s);
      nx();
      n_tests++;
      if (resp_valid !== 1'b1 || resp_meta !== exp_meta(s) || resp_hit !== 4'b0000) begin
        n_fail++;
        $display("FAIL flush_clear set %0d: got v=%b meta=%h hit=%b want 1 %h 0000",
                 s, resp_valid, resp_meta, resp_hit, exp_meta(s));
      end
    end
    rd_valid = 2'b00;
    nx();
  endtask

  task automatic test_reset_mid_response();
    wr_valid = 1'b1;
    wr_idx = IDX'(3);
    wr_way_en = 4'b1000;
    wr_tag = 20'h0F0F0;
    wr_coh = 2'd1;
    nx();
    wr_valid = 1'b0;
    rd_valid = 2'b01;
    rd_idx[0 +: IDX] = IDX'(3);
    rd_tag[0 +: TB] = 20'h0F0F0;
    nx();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_hit !== 4'b1000) begin
      n_fail++;
      $display("FAIL pre_reset_resp: got v=%b hit=%b want 1 1000", resp_valid, resp_hit);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || resp_meta !== '0 || resp_hit !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b done=%b hit=%b want 0 0 0000",
               resp_valid, init_done, resp_hit);
    end
    nx();
    reset_n = 1'b1;
    repeat (20) nx();
    #1 reset_n = 1'b0;
    nx();
    reset_n = 1'b1;
    model_clear();
    for (int k = 0; k < NS; k++) begin
      #1;
      n_tests++;
      if (init_done !== 1'b0 || rd_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL restart_sweep cyc %0d: got done=%b rdy=%b want 0 00",
                 k, init_done, rd_ready);
      end
      nx();
    end
    #1;
    n_tests++;
    if (init_done !== 1'b1 || rd_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_done: got done=%b rdy=%b want 1 01", init_done, rd_ready);
    end
    nx();
    rd_valid = 2'b00;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_meta !== exp_meta(3) || resp_hit !== 4'b0000) begin
      n_fail++;
      $display("FAIL restart_clear: got v=%b meta=%h hit=%b want 1 %h 0000",
               resp_valid, resp_meta, resp_hit, exp_meta(3));
    end
    nx();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_coh_zero();
    test_random();
    test_flush();
    test_reset_mid_response();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
